// File: rtl/number_sprite_pkg.sv
// Shared constants and types for the digit sprite renderer.
package number_sprite_pkg;

  localparam int SPRITE_W = 20;
  localparam int SPRITE_H = 20;
  localparam int PIX_W    = 8;
  localparam logic [PIX_W-1:0] TRANSPARENT = 8'h00;

  // Raster coordinate type (10-bit covers a 640x480 screen).
  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sprite_delay_line.sv
// N-stage, W-bit shift register with synchronous clear.
// Keeps per-pixel side information aligned with the ROM read pipeline.
module sprite_delay_line #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         i_clk2,
  input  logic         i_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] pipe;

  // Shift one stage per clock; reset empties every stage.
  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[N-1];

endmodule

// File: rtl/number_sprite_renderer.sv
// Digit sprite address generator and compositor.
// Screen coordinate -> ROM address (stage 1), ROM data (stage 2),
// colour-keyed composite over background (stage 3).
// Optional: define NUMBER_SPRITE_SCALE2X_EN to draw each texel as 2x2 pixels.
module number_sprite_renderer #(
  parameter int SPRITE_W = number_sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = number_sprite_pkg::SPRITE_H,
  parameter int ADDR_W   = 10,
  parameter int PIX_W    = number_sprite_pkg::PIX_W,
  parameter logic [PIX_W-1:0] TRANSPARENT = number_sprite_pkg::TRANSPARENT
) (
  input  logic              i_clk2,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_pix_valid,
  input  logic [9:0]        i_pos_x,
  input  logic [9:0]        i_pos_y,
  input  logic [PIX_W-1:0]  i_bg_pixel,
  output logic [ADDR_W-1:0] o_numberaddr,
  input  logic [PIX_W-1:0]  i_numberdata,
  output logic [PIX_W-1:0]  o_pixel,
  output logic              o_pixel_valid,
  output logic              o_sprite_hit
);
  import number_sprite_pkg::*;

`ifdef NUMBER_SPRITE_SCALE2X_EN
  localparam int FOOT_W = 2 * SPRITE_W;
  localparam int FOOT_H = 2 * SPRITE_H;
`else
  localparam int FOOT_W = SPRITE_W;
  localparam int FOOT_H = SPRITE_H;
`endif
  localparam int ROW_W = $clog2(SPRITE_H + 1);
  localparam logic [10:0] FOOT_W_X = 11'(FOOT_W);
  localparam logic [10:0] FOOT_H_X = 11'(FOOT_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPRITE_W);
  localparam int TAG_W = PIX_W + 2;

  state_e              state_q, state_d;
  coord_t              pos_x_q, pos_y_q;
  logic [ADDR_W-1:0]   row_base_q, row_base_nxt, col;
  logic [ROW_W-1:0]    row_q, cur_row;
  logic [10:0]         x_w, y_w, px_w, py_w, dx, dy;
  logic                in_x, in_y, hit, last_hit;
  logic [TAG_W-1:0]    tag_d, tag_q;
  logic                d_hit, d_valid;
  logic [PIX_W-1:0]    d_bg;

  // 11-bit arithmetic so a sprite hanging off the right/bottom edge clips
  // instead of wrapping back onto column/row 0.
  assign x_w  = {1'b0, i_x};
  assign y_w  = {1'b0, i_y};
  assign px_w = {1'b0, pos_x_q};
  assign py_w = {1'b0, pos_y_q};
  assign dx   = x_w - px_w;
  assign dy   = y_w - py_w;
  assign in_x = (x_w >= px_w) && (x_w < px_w + FOOT_W_X);
  assign in_y = (y_w >= py_w) && (y_w < py_w + FOOT_H_X);

  // A frame_start cycle only re-arms; it never issues a texel itself.
  assign hit = i_pix_valid && in_x && in_y && !i_frame_start &&
               ((state_q == WAIT) || (state_q == DRAW));
  assign last_hit = hit && (dx == FOOT_W_X - 11'd1) && (dy == FOOT_H_X - 11'd1);

`ifdef NUMBER_SPRITE_SCALE2X_EN
  assign col     = ADDR_W'(dx >> 1);
  assign cur_row = ROW_W'(dy >> 1);
`else
  assign col     = ADDR_W'(dx);
  assign cur_row = ROW_W'(dy);
`endif

  // Row base moves by one sprite row whenever the texel row changes, so a
  // right-clipped row (last column never seen) still advances correctly.
  assign row_base_nxt = (cur_row == row_q) ? row_base_q : row_base_q + ROW_STEP;

  // State register.
  always_ff @(posedge i_clk2) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: frame_start always restarts; the final texel ends the frame.
  always_comb begin
    state_d = state_q;
    if (i_frame_start) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        WAIT:    if (last_hit) state_d = DONE;
                 else if (hit) state_d = DRAW;
        DRAW:    if (last_hit) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Stage 1: latch sprite position per frame and register the ROM address.
  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      row_base_q   <= '0;
      row_q        <= '0;
      o_numberaddr <= '0;
    end else if (i_frame_start) begin
      pos_x_q    <= i_pos_x;
      pos_y_q    <= i_pos_y;
      row_base_q <= '0;
      row_q      <= '0;
    end else if (hit) begin
      o_numberaddr <= row_base_nxt + col;
      row_base_q   <= row_base_nxt;
      row_q        <= cur_row;
    end
  end

  // Hit/valid/background ride alongside the address and ROM stages.
  assign tag_d = {hit, i_pix_valid, i_bg_pixel};

  sprite_delay_line #(.N(2), .W(TAG_W)) u_align (
    .i_clk2 (i_clk2),
    .i_rst  (i_rst),
    .d      (tag_d),
    .q      (tag_q)
  );

  assign d_hit   = tag_q[TAG_W-1];
  assign d_valid = tag_q[TAG_W-2];
  assign d_bg    = tag_q[PIX_W-1:0];

  // Stage 3: colour-keyed composite; blanked output is forced to zero.
  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_sprite_hit  <= 1'b0;
    end else begin
      o_pixel_valid <= d_valid;
      if (!d_valid) begin
        o_pixel      <= '0;
        o_sprite_hit <= 1'b0;
      end else if (d_hit && (i_numberdata != TRANSPARENT)) begin
        o_pixel      <= i_numberdata;
        o_sprite_hit <= 1'b1;
      end else begin
        o_pixel      <= d_bg;
        o_sprite_hit <= 1'b0;
      end
    end
  end

endmodule

// File: doc/number_sprite_renderer.md
Name: number_sprite_renderer

Overview:
- Raster-side address generator and pixel compositor for one 20x20 digit sprite ROM (8-bit pixels, 1-cycle registered read).
- Sits between the VGA timing/coordinate stage and the colour output mux.
- Converts the current screen coordinate into a ROM address and re-aligns the returned pixel with the pipelined coordinate.
- Composites the pixel over a background value using a transparent colour key.

Parameters:
- SPRITE_W, 20, sprite width in pixels
- SPRITE_H, 20, sprite height in pixels
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H
- PIX_W, 8, pixel data width
- TRANSPARENT, 8'h00, colour key; ROM pixels equal to it show the background

Ports:
- i_clk2  in  1  pixel clock, shared with the sprite ROM
- i_rst  in  1  synchronous active-high reset
- i_frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- i_x  in  10  current pixel column
- i_y  in  10  current pixel row
- i_pix_valid  in  1  i_x/i_y are in active video
- i_pos_x  in  10  sprite left edge; sampled on i_frame_start
- i_pos_y  in  10  sprite top edge; sampled on i_frame_start
- i_bg_pixel  in  PIX_W  background pixel for the current coordinate
- o_numberaddr  out  ADDR_W  ROM address, registered
- i_numberdata  in  PIX_W  ROM data; valid one cycle after o_numberaddr
- o_pixel  out  PIX_W  composited pixel
- o_pixel_valid  out  1  o_pixel corresponds to an active-video input
- o_sprite_hit  out  1  o_pixel came from a non-transparent sprite texel

Behaviour:
- Reset (synchronous, i_rst high):
  - o_numberaddr=0, o_pixel=0, o_pixel_valid=0, o_sprite_hit=0.
  - Latched positions=0; row_base=0; all pipeline valid bits cleared; state=IDLE.
  - A reset asserted mid-draw takes effect on that same edge. Nothing drawn until the next i_frame_start.
- States:
  - IDLE: leaves only on i_frame_start.
  - WAIT: positions latched, sprite not yet reached.
  - DRAW: at least one sprite pixel issued.
  - DONE: all SPRITE_H rows issued; no hits until the next frame.
- i_frame_start, from any state except during reset: latch i_pos_x/i_pos_y, clear row_base and row counter, go to WAIT. A pulse during DRAW aborts the current frame and restarts it.
- Hit (stage 0): i_pix_valid and pos_x <= i_x < pos_x+SPRITE_W and pos_y <= i_y < pos_y+SPRITE_H, in state WAIT or DRAW.
  - Comparisons use 11-bit sums, so a sprite near the screen edge clips and never wraps.
- Address:
  - col = i_x - pos_x.
  - o_numberaddr <= row_base + col, registered on each hit.
  - On non-hit cycles o_numberaddr holds its value.
  - No multiplier: row_base += SPRITE_W after the hit where col == SPRITE_W-1.
  - When the row counter reaches SPRITE_H, go to DONE. The address therefore never exceeds SPRITE_W*SPRITE_H-1.
  - A row whose right portion is clipped off-screen still advances row_base on the first hit of the next sprite row. Track the row as i_y - pos_y and recompute row_base = row*SPRITE_W incrementally on row change.
- Pipeline:
  - Stage 1: address registered. Stage 2: ROM data returned. Stage 3: o_pixel registered.
  - Latency from i_x/i_y to o_pixel is 3 cycles.
  - hit, i_pix_valid and i_bg_pixel are delayed 3 cycles to stay aligned.
- Compositing (stage 3):
  - If delayed hit is set and ROM data != TRANSPARENT: o_pixel = ROM data, o_sprite_hit=1.
  - Otherwise: o_pixel = delayed bg, o_sprite_hit=0.
  - o_pixel_valid = delayed i_pix_valid.
  - When o_pixel_valid=0, o_pixel=0.
- Throughput: one pixel per clock; no stalls, no backpressure.

Optional Feature:
- Macro: NUMBER_SPRITE_SCALE2X_EN.
- Defined:
  - Footprint becomes 2*SPRITE_W x 2*SPRITE_H.
  - col = (i_x - pos_x) >> 1; row index = (i_y - pos_y) >> 1.
  - row_base advances once per two screen rows.
  - Latency unchanged.
- Undefined: 1:1 mapping as above. No scale logic is synthesised.

Decomposition:
- Shared package number_sprite_pkg holds:
  - SPRITE_W, SPRITE_H, PIX_W, TRANSPARENT.
  - State enum IDLE/WAIT/DRAW/DONE.
  - Screen-width constant (10-bit coordinate type).
- One natural sub-module: sprite_delay_line. It is a parameterised N-stage, W-bit shift register with a synchronous clear, used for the hit/valid/bg alignment.

Test Plan:
- Reset held 5 cycles mid-frame at sprite (100,50) -> all outputs 0 and state IDLE; i_x=100, i_y=50 afterwards with no frame_start -> o_sprite_hit stays 0.
- frame_start with pos (100,50); raster (100,50) -> o_numberaddr=0 one cycle later; (119,50) -> 19; (100,51) -> 20; (119,69) -> 399; o_pixel equals ROM data exactly 3 cycles after each coordinate.
- ROM model returns 8'h00 at addr 5 and bg=8'h3C -> o_pixel=8'h3C and o_sprite_hit=0 on that pixel; neighbouring texels show ROM data.
- Sprite at (630,470) on a 640x480 raster -> only addresses col 0..9 of rows 0..9 issued; no wrap hits at x<10; next frame behaves identically.
- frame_start re-pulsed mid-draw (row 7) with new pos (10,10) -> row_base restarts; the first hit at (10,10) gives addr 0.
- With NUMBER_SPRITE_SCALE2X_EN, pos (0,0) -> (0,0),(1,0),(0,1),(1,1) all give addr 0; (2,0) gives 1; (0,2) gives 20; (39,39) gives 399.
